adder_tree_seq: RTL

ADDER_TREE_SEQ -- requirements
Module: adder_tree_seq

---
 rtl/adder_tree_seq.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/adder_tree_seq.sv
// Three-sum adder tree (a+b, c+d, total) time-multiplexed onto one shared 10-bit adder.
// Optional build macro ADDER_TREE_ACCUM_EN adds a 16-bit wrapping accumulator of sum3.
module adder_tree_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  a,
    input  logic [3:0]  b,
    input  logic [7:0]  c,
    input  logic [7:0]  d,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  sum1,
    output logic [8:0]  sum2,
    output logic [9:0]  sum3,
    output logic        busy
`ifdef ADDER_TREE_ACCUM_EN
    ,
    input  logic        acc_clr,
    output logic [15:0] acc
`endif
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADD1 = 3'd1,
        ADD2 = 3'd2,
        ADD3 = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state;
    logic [3:0]  a_q;
    logic [3:0]  b_q;
    logic [7:0]  c_q;
    logic [7:0]  d_q;
    logic [9:0]  add_x;
    logic [9:0]  add_z;
    logic [9:0]  add_y;
    logic        in_xfer;
    logic        out_xfer;

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // in_ready is combinational so a waiting consumer can chain the next set from DONE.
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Operand select for the single shared adder; widths keep every sum overflow-free.
    always_comb begin
        add_x = 10'd0;
        add_z = 10'd0;
        case (state)
            ADD1: begin
                add_x = {6'd0, a_q};
                add_z = {6'd0, b_q};
            end
            ADD2: begin
                add_x = {2'd0, c_q};
                add_z = {2'd0, d_q};
            end
            ADD3: begin
                add_x = {5'd0, sum1};
                add_z = {1'b0, sum2};
            end
            default: begin
                add_x = 10'd0;
                add_z = 10'd0;
            end
        endcase
    end

    assign add_y = add_x + add_z;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            a_q       <= 4'd0;
            b_q       <= 4'd0;
            c_q       <= 8'd0;
            d_q       <= 8'd0;
            sum1      <= 5'd0;
            sum2      <= 9'd0;
            sum3      <= 10'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_xfer) begin
                        a_q   <= a;
                        b_q   <= b;
                        c_q   <= c;
                        d_q   <= d;
                        state <= ADD1;
                        busy  <= 1'b1;
                    end
                end
                ADD1: begin
                    sum1  <= add_y[4:0];
                    state <= ADD2;
                end
                ADD2: begin
                    sum2  <= add_y[8:0];
                    state <= ADD3;
                end
                ADD3: begin
                    sum3      <= add_y;
                    state     <= DONE;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    // Results stay frozen until the consumer takes them.
                    if (out_xfer) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            a_q   <= a;
                            b_q   <= b;
                            c_q   <= c;
                            d_q   <= d;
                            state <= ADD1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef ADDER_TREE_ACCUM_EN
    // A clear coinciding with a transfer restarts the running total at that result.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= 16'd0;
        end else if (out_xfer) begin
            if (acc_clr) begin
                acc <= {6'd0, sum3};
            end else begin
                acc <= acc + {6'd0, sum3};
            end
        end else if (acc_clr) begin
            acc <= 16'd0;
        end
    end
`endif

endmodule
